// File: rtl/idli_pkg.sv
// Shared types for the idli SQI memory responder: nibble type, opcodes, FSM states.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [7:0] {
    SQI_WRITE = 8'h02,
    SQI_READ  = 8'h03
  } sqi_op_e;

  // state   | meaning
  // CMD     | collecting the two opcode nibbles
  // ADDR    | collecting the six address nibbles
  // DUMMY   | turnaround cycles before read data
  // RD_DATA | driving bytes from storage, high nibble first
  // WR_DATA | assembling bytes from the initiator and storing them
  // IGNORE  | unknown opcode, idle until chip select drops
  typedef enum logic [2:0] {
    CMD,
    ADDR,
    DUMMY,
    RD_DATA,
    WR_DATA,
    IGNORE
  } sqi_state_e;

endpackage

// File: rtl/idli_sqi_mem_ram_m.sv
// Byte storage for the SQI responder: one synchronous write port and one asynchronous read port.
// IDLI_SQI_MEM_BACKDOOR_EN adds a backdoor write port for preloading while the SQI bus is idle.
module idli_sqi_mem_ram_m #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
`ifdef IDLI_SQI_MEM_BACKDOOR_EN
  ,
  input  logic              bd_clk,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_data
`endif
);

  logic [7:0]        mem [2**ADDR_W];
  logic              wr_clk;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

`ifdef IDLI_SQI_MEM_BACKDOOR_EN
  // Backdoor is only used while sck idles low, so the two clocks never overlap.
  assign wr_clk  = clk | bd_clk;
  assign wr_en   = bd_we | we;
  assign wr_addr = bd_we ? bd_addr : waddr;
  assign wr_data = bd_we ? bd_data : wdata;
`else
  assign wr_clk  = clk;
  assign wr_en   = we;
  assign wr_addr = waddr;
  assign wr_data = wdata;
`endif

  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder: read (0x03) and write (0x02) with 24-bit address and auto-increment.
// IDLI_SQI_MEM_BACKDOOR_EN exposes the storage backdoor write port for bench preload.
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DUMMY_CYC = 2
) (
  input  logic              i_sqi_sck,
  input  logic              rst_n,
  input  logic              i_sqi_cs,
  input  sqi_data_t         i_sqi_sio,
  output sqi_data_t         o_sqi_sio,
  output logic              o_sqi_sio_oe
`ifdef IDLI_SQI_MEM_BACKDOOR_EN
  ,
  input  logic              i_bd_clk,
  input  logic              i_bd_we,
  input  logic [ADDR_W-1:0] i_bd_addr,
  input  logic [7:0]        i_bd_data
`endif
);

  localparam logic [7:0] DLY_LOAD = 8'((DUMMY_CYC > 0) ? DUMMY_CYC - 1 : 0);

  sqi_state_e        state, state_nx;
  logic [2:0]        nib_cnt, nib_cnt_nx;
  logic [7:0]        dly_cnt, dly_cnt_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  sqi_data_t         op_hi, op_hi_nx;
  sqi_data_t         wr_hi, wr_hi_nx;
  logic              is_wr, is_wr_nx;
  logic              nib_lo, nib_lo_nx;
  logic              wr_en;
  logic [7:0]        rd_byte;
  logic              arst_n;
  logic              oe_q;
  sqi_data_t         sio_q;

  // Chip select deassertion aborts a transaction exactly like reset does.
  assign arst_n = rst_n & ~i_sqi_cs;

  always_ff @(posedge i_sqi_sck or negedge arst_n) begin
    if (!arst_n) begin
      state   <= CMD;
      nib_cnt <= '0;
      dly_cnt <= '0;
      addr    <= '0;
      op_hi   <= '0;
      wr_hi   <= '0;
      is_wr   <= 1'b0;
      nib_lo  <= 1'b0;
    end else begin
      state   <= state_nx;
      nib_cnt <= nib_cnt_nx;
      dly_cnt <= dly_cnt_nx;
      addr    <= addr_nx;
      op_hi   <= op_hi_nx;
      wr_hi   <= wr_hi_nx;
      is_wr   <= is_wr_nx;
      nib_lo  <= nib_lo_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    nib_cnt_nx = nib_cnt;
    dly_cnt_nx = dly_cnt;
    addr_nx    = addr;
    op_hi_nx   = op_hi;
    wr_hi_nx   = wr_hi;
    is_wr_nx   = is_wr;
    nib_lo_nx  = nib_lo;
    wr_en      = 1'b0;
    case (state)
      CMD: begin
        if (nib_cnt == 3'd1) begin
          nib_cnt_nx = '0;
          case ({op_hi, i_sqi_sio})
            SQI_READ: begin
              is_wr_nx = 1'b0;
              state_nx = ADDR;
            end
            SQI_WRITE: begin
              is_wr_nx = 1'b1;
              state_nx = ADDR;
            end
            default: state_nx = IGNORE;
          endcase
        end else begin
          op_hi_nx   = i_sqi_sio;
          nib_cnt_nx = nib_cnt + 3'd1;
        end
      end
      ADDR: begin
        // Shifting into the address register drops bits above ADDR_W for free.
        addr_nx = {addr[ADDR_W-5:0], i_sqi_sio};
        if (nib_cnt == 3'd5) begin
          nib_cnt_nx = '0;
          nib_lo_nx  = 1'b0;
          if (is_wr) begin
            state_nx = WR_DATA;
          end else if (DUMMY_CYC == 0) begin
            state_nx = RD_DATA;
          end else begin
            state_nx   = DUMMY;
            dly_cnt_nx = DLY_LOAD;
          end
        end else begin
          nib_cnt_nx = nib_cnt + 3'd1;
        end
      end
      DUMMY: begin
        if (dly_cnt == '0) state_nx = RD_DATA;
        else               dly_cnt_nx = dly_cnt - 8'd1;
      end
      RD_DATA: begin
        nib_lo_nx = ~nib_lo;
        if (nib_lo) addr_nx = addr + 1'b1;
      end
      WR_DATA: begin
        nib_lo_nx = ~nib_lo;
        if (nib_lo) begin
          wr_en   = 1'b1;
          addr_nx = addr + 1'b1;
        end else begin
          wr_hi_nx = i_sqi_sio;
        end
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(negedge i_sqi_sck or negedge arst_n) begin
    if (!arst_n) begin
      oe_q  <= 1'b0;
      sio_q <= '0;
    end else if (state == RD_DATA) begin
      oe_q  <= 1'b1;
      sio_q <= nib_lo ? rd_byte[3:0] : rd_byte[7:4];
    end else begin
      oe_q  <= 1'b0;
      sio_q <= '0;
    end
  end

  assign o_sqi_sio    = sio_q;
  assign o_sqi_sio_oe = oe_q;

  idli_sqi_mem_ram_m #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (i_sqi_sck),
    .we     (wr_en),
    .waddr  (addr),
    .wdata  ({wr_hi, i_sqi_sio}),
    .raddr  (addr),
    .rdata  (rd_byte)
`ifdef IDLI_SQI_MEM_BACKDOOR_EN
    ,
    .bd_clk (i_bd_clk),
    .bd_we  (i_bd_we),
    .bd_addr(i_bd_addr),
    .bd_data(i_bd_data)
`endif
  );

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Self-checking bench for idli_sqi_mem_m: byte-array model of storage plus per-nibble expectations.
module tb_idli_sqi_mem_m;
  localparam int D = 2;

  logic       sck = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b1;
  logic [3:0] sio_in = 4'h0;
  logic [3:0] sio_out;
  logic       oe;
`ifdef IDLI_SQI_MEM_BACKDOOR_EN
  logic        bd_clk = 1'b0;
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;
`endif

  idli_sqi_mem_m #(.ADDR_W(16), .DUMMY_CYC(D)) dut (
    .i_sqi_sck   (sck),
    .rst_n       (rst_n),
    .i_sqi_cs    (cs),
    .i_sqi_sio   (sio_in),
    .o_sqi_sio   (sio_out),
    .o_sqi_sio_oe(oe)
`ifdef IDLI_SQI_MEM_BACKDOOR_EN
    ,
    .i_bd_clk    (bd_clk),
    .i_bd_we     (bd_we),
    .i_bd_addr   (bd_addr),
    .i_bd_data   (bd_data)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_m [0:65535];
  bit         known [0:65535];

  logic       cmp_en = 1'b0;
  logic       exp_oe = 1'b0;
  logic [3:0] exp_sio = 4'h0;
  logic       exp_known = 1'b1;

  logic [3:0] rd_q[$];
  int         first_oe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of the outputs against the model, away from the driving edge.
  always @(negedge sck) begin
    #2;
    if (cmp_en) begin
      chk("oe", {31'b0, oe}, {31'b0, exp_oe});
      if (exp_known) chk("sio", {28'b0, sio_out}, {28'b0, exp_sio});
    end
  end

  // One cs-low transaction of n_edges rising edges; payload feeds write data or ignored nibbles.
  // abort_at > 0 pulses rst_n low after the falling edge following that rising edge.
  task automatic txn(input logic [7:0] op, input logic [23:0] a24, input int n_edges,
                     input logic [3:0] pay[$], input int abort_at);
    int         a;
    int         j;
    int         p;
    logic [3:0] nib;
    logic [3:0] hi;
    logic [7:0] b;
    a = int'(a24[15:0]);
    hi = 4'h0;
    rd_q.delete();
    first_oe = -1;
    cs = 1'b0;
    #5;
    cmp_en = 1'b1;
    for (int n = 1; n <= n_edges; n++) begin
      if (n <= 2) nib = (n == 1) ? op[7:4] : op[3:0];
      else if (n <= 8) nib = 4'((a24 >> (4 * (8 - n))) & 24'hF);
      else begin
        p = (op == 8'h02) ? n - 9 : n - 3;
        if (op != 8'h03 && p < pay.size()) nib = pay[p];
        else nib = 4'($urandom_range(15, 0));
      end
      sio_in = nib;
      #5 sck = 1'b1;
      exp_oe = 1'b0;
      exp_sio = 4'h0;
      exp_known = 1'b1;
      if (op == 8'h02 && n >= 9) begin
        j = n - 9;
        if (j % 2 == 1) begin
          mem_m[(a + j / 2) & 16'hFFFF] = {hi, nib};
          known[(a + j / 2) & 16'hFFFF] = 1'b1;
        end else hi = nib;
      end
      if (op == 8'h03 && n >= 8 + D) begin
        j = n - 8 - D;
        b = mem_m[(a + j / 2) & 16'hFFFF];
        exp_oe = 1'b1;
        exp_sio = (j % 2 == 1) ? b[3:0] : b[7:4];
        exp_known = known[(a + j / 2) & 16'hFFFF];
      end
      #5 sck = 1'b0;
      #2;
      if (oe) begin
        rd_q.push_back(sio_out);
        if (first_oe < 0) first_oe = n;
      end
      #3;
      if (n == abort_at) begin
        cmp_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_oe", {31'b0, oe}, 32'd0);
        chk("rst_sio", {28'b0, sio_out}, 32'd0);
        break;
      end
    end
    cmp_en = 1'b0;
    cs = 1'b1;
    #1;
    chk("cs_oe", {31'b0, oe}, 32'd0);
    chk("cs_sio", {28'b0, sio_out}, 32'd0);
    rst_n = 1'b1;
    #9;
  endtask

  task automatic write_bytes(input logic [23:0] a24, input logic [7:0] data[$]);
    logic [3:0] pay[$];
    foreach (data[i]) begin
      pay.push_back(data[i][7:4]);
      pay.push_back(data[i][3:0]);
    end
    txn(8'h02, a24, 8 + pay.size(), pay, 0);
  endtask

  task automatic read_nibs(input logic [23:0] a24, input int nn);
    logic [3:0] none[$];
    txn(8'h03, a24, 8 + D + nn, none, 0);
  endtask

  logic [7:0] bytes[$];
  logic [3:0] pay[$];
  logic [7:0] save21;
  logic [23:0] ra;

  initial begin
    for (int i = 0; i < 65536; i++) known[i] = 1'b0;
    #3;
    chk("reset_oe", {31'b0, oe}, 32'd0);
    chk("reset_sio", {28'b0, sio_out}, 32'd0);
    rst_n = 1'b1;
    #10;

    bytes.delete();
    for (int i = 0; i < 64; i++) bytes.push_back(8'($urandom));
    write_bytes(24'h000000, bytes);
    bytes.delete();
    for (int i = 0; i < 16; i++) bytes.push_back(8'($urandom));
    write_bytes(24'h00FFF0, bytes);

    // Basic write then read of two bytes.
    bytes = '{8'hA5, 8'h3C};
    write_bytes(24'h000010, bytes);
    read_nibs(24'h000010, 4);
    chk("rd_size", rd_q.size(), 32'd5);
    chk("rd_n0", {28'b0, rd_q[0]}, 32'hA);
    chk("rd_n1", {28'b0, rd_q[1]}, 32'h5);
    chk("rd_n2", {28'b0, rd_q[2]}, 32'h3);
    chk("rd_n3", {28'b0, rd_q[3]}, 32'hC);
    chk("first_oe_edge", first_oe, 32'd10);

    // Address wrap at the top of storage.
    bytes = '{8'h11, 8'h22};
    write_bytes(24'h00FFFF, bytes);
    read_nibs(24'h000000, 2);
    chk("wrap_lo", {24'b0, rd_q[0], rd_q[1]}, 32'h22);
    read_nibs(24'h00FFFF, 4);
    chk("wrap_hi0", {24'b0, rd_q[0], rd_q[1]}, 32'h11);
    chk("wrap_hi1", {24'b0, rd_q[2], rd_q[3]}, 32'h22);

    // Unknown opcode: bus stays quiet and storage is untouched.
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(4'h7);
    txn(8'hFF, 24'h0, 22, pay, 0);
    chk("ign_first_oe", first_oe, 32'hFFFFFFFF);
    read_nibs(24'h000000, 128);
    chk("ign_keep10", {24'b0, rd_q[32], rd_q[33]}, 32'hA5);

    // Partial write byte is discarded.
    save21 = mem_m[16'h21];
    pay = '{4'h9, 4'h8, 4'h7};
    txn(8'h02, 24'h000020, 11, pay, 0);
    read_nibs(24'h000020, 4);
    chk("part_20", {24'b0, rd_q[0], rd_q[1]}, 32'h98);
    chk("part_21", {24'b0, rd_q[2], rd_q[3]}, {24'b0, save21});

    // Reset during read data, then a normal read.
    txn(8'h03, 24'h000010, 14, pay, 11);
    read_nibs(24'h000010, 2);
    chk("post_rst", {24'b0, rd_q[0], rd_q[1]}, 32'hA5);

    // Upper address bits are ignored.
    read_nibs(24'hAB0010, 2);
    chk("hi_addr_ign", {24'b0, rd_q[0], rd_q[1]}, 32'hA5);

    // Randomized writes (some ending mid-byte) and reads against the model.
    for (int t = 0; t < 24; t++) begin
      ra = 24'($urandom);
      pay.delete();
      for (int i = 0; i < int'($urandom_range(12, 1)); i++) pay.push_back(4'($urandom));
      txn(8'h02, ra, 8 + pay.size(), pay, 0);
      read_nibs(ra, int'($urandom_range(12, 1)));
      if ($urandom_range(3, 0) == 0) begin
        read_nibs(24'($urandom_range(63, 0)), int'($urandom_range(16, 1)));
      end
    end

`ifdef IDLI_SQI_MEM_BACKDOOR_EN
    bd_addr = 16'h1234;
    bd_data = 8'h5E;
    bd_we = 1'b1;
    #2 bd_clk = 1'b1;
    #2 bd_clk = 1'b0;
    bd_we = 1'b0;
    mem_m[16'h1234] = 8'h5E;
    known[16'h1234] = 1'b1;
    #5;
    read_nibs(24'h001234, 2);
    chk("bd_n0", {28'b0, rd_q[0]}, 32'h5);
    chk("bd_n1", {28'b0, rd_q[1]}, 32'hE);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/idli_sqi_mem_m.md
IDLI_SQI_MEM_M -- requirements
Module: idli_sqi_mem_m

Interface
REQ-001 Parameter ADDR_W, 16: byte-address width of storage; storage is 2^ADDR_W bytes.
REQ-002 Parameter DUMMY_CYC, 2: sck cycles between the last address nibble and the first read data nibble.
REQ-003 i_sqi_sck  input  1: SQI clock from initiator; block clock; inputs sampled on rising edge, outputs updated on falling edge.
REQ-004 rst_n  input  1: reset; asynchronous, active-low.
REQ-005 i_sqi_cs  input  1: chip select, active-low.
REQ-006 i_sqi_sio  input  sqi_data_t (4): nibble from initiator.
REQ-007 o_sqi_sio  output  sqi_data_t (4): nibble to initiator.
REQ-008 o_sqi_sio_oe  output  1: high while the block drives o_sqi_sio.

Function
REQ-009 The block SHALL act as an SQI serial-SRAM responder: MSB nibble first, 4 bits per rising sck.
REQ-010 FSM states SHALL be CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE; entry state CMD.
REQ-011 CMD: 2 nibbles form an 8-bit opcode; 0x03 -> ADDR (read), 0x02 -> ADDR (write), any other -> IGNORE.
REQ-012 ADDR: 6 nibbles form a 24-bit address; bits [23:ADDR_W] SHALL be ignored; then read -> DUMMY, write -> WR_DATA.
REQ-013 DUMMY: DUMMY_CYC rising edges, input ignored, then RD_DATA; DUMMY_CYC=0 goes directly to RD_DATA.
REQ-014 RD_DATA: byte at current address driven high nibble then low nibble; o_sqi_sio_oe and first nibble SHALL change on the falling edge after the last dummy rising edge (default: 10th rising edge of the transaction).
REQ-015 WR_DATA: byte assembled from two nibbles, written to storage on the rising edge sampling the low nibble.
REQ-016 Address SHALL increment by 1 after each full byte (read or write) and wrap modulo 2^ADDR_W (0xFFFF -> 0x0000 at default).
REQ-017 IGNORE: all input ignored, o_sqi_sio_oe low, until i_sqi_cs deasserts.
REQ-018 i_sqi_cs high SHALL asynchronously return FSM to CMD, clear nibble/address counters, and deassert o_sqi_sio_oe.
REQ-019 A write byte with only its high nibble received when i_sqi_cs deasserts SHALL be discarded; storage unchanged.
REQ-020 A read terminated mid-byte SHALL not affect storage or the next transaction.
REQ-021 o_sqi_sio SHALL be 0 whenever o_sqi_sio_oe is low.
REQ-022 Back-to-back transactions separated by a single sck-free cs-high interval SHALL be supported with no lost state.

Reset
REQ-023 rst_n low SHALL force state CMD, counters 0, o_sqi_sio 0, o_sqi_sio_oe 0.
REQ-024 Storage contents SHALL NOT be reset by rst_n or i_sqi_cs.
REQ-025 rst_n asserted mid-transaction SHALL abort it; a partially received write byte is discarded.

Configuration
REQ-026 Macro IDLI_SQI_MEM_BACKDOOR_EN defined: ports i_bd_clk (1), i_bd_we (1), i_bd_addr (ADDR_W), i_bd_data (8) SHALL exist; storage[i_bd_addr] <= i_bd_data on rising i_bd_clk when i_bd_we, for bench preload while i_sqi_cs is high.
REQ-027 Macro undefined: those ports SHALL be absent; storage writable only via SQI write commands.
REQ-028 Simultaneous backdoor and SQI writes SHALL be a bench error; result undefined.

Structure
REQ-029 idli_pkg SHALL hold sqi_data_t (existing), the opcode enum (SQI_READ=0x03, SQI_WRITE=0x02) and the FSM state enum.
REQ-030 Storage SHALL live in sub-module idli_sqi_mem_ram_m: one synchronous write port, one asynchronous read port, optional backdoor write port.
REQ-031 Implementation target: 120-400 lines of RTL total.

Verification
REQ-032 Write 0x02, addr 0x000010, data 0xA5 0x3C; read 0x03, addr 0x000010 -> nibbles A,5,3,C on rising edges 11-14, oe high from falling edge after edge 10.
REQ-033 Write 0x02 addr 0x00FFFF data 0x11 0x22; read addr 0x000000 -> 0x22; read addr 0x00FFFF -> 0x11 (wrap).
REQ-034 Opcode 0xFF, then 20 nibbles of 0x7 -> oe stays 0, storage unchanged; next cs cycle with read 0x03 works normally.
REQ-035 Write addr 0x20, nibbles 0x9,0x8,0x7 then cs high -> storage[0x20]=0x98, storage[0x21] unchanged.
REQ-036 rst_n pulsed low during RD_DATA -> oe 0 and o_sqi_sio 0 immediately; subsequent read of 0x10 returns 0xA5.
REQ-037 With IDLI_SQI_MEM_BACKDOOR_EN: preload 0x1234 <- 0x5E via backdoor; SQI read 0x1234 -> nibbles 5,E.
